memory_access: RTL and testbench

- MEM stage of the 5-stage pipelined RV32IM core. Sits between the execute stage's EX/MEM register and writeback.
- Drives a variable-latency data-memory request/response port and aligns store data and byte-enables.
- Sign/zero-extends load data, detects misaligned accesses and raises mem_stall while memory is pending.
- Owns the MEM/WB pipeline register.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/load_extend.sv | 34 +++
 rtl/memory_access.sv | 179 +++++++++++++++++
 tb/tb_memory_access.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: load/store funct3 codes, writeback
// source selects and the request-sequencing state type.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_REQ      = 2'b01,
        S_WAIT_RSP = 2'b10
    } mem_state_t;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module load_extend
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MEM stage: sequences data-memory requests, aligns store lanes, extends
// loads, flags misaligned accesses and owns the MEM/WB register.
module memory_access
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] ALU_out_EXMEM,
    input  logic [2:0]      funct3_EXMEM,
    input  logic            mem_wr_en_EXMEM,
    input  logic [XLEN-1:0] rs2_data_EXMEM,
    input  logic            reg_wr_en_EXMEM,
    input  logic [1:0]      reg_wr_ctrl_EXMEM,
    input  logic [4:0]      rd_EXMEM,
    input  logic [XLEN-1:0] pc_4_EXMEM,
    input  logic            halt_MEM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic            misaligned_fault,
    output logic [XLEN-1:0] ALU_out_MEMWB,
    output logic [XLEN-1:0] load_data_MEMWB,
    output logic            reg_wr_en_MEMWB,
    output logic [1:0]      reg_wr_ctrl_MEMWB,
    output logic [4:0]      rd_MEMWB,
    output logic [XLEN-1:0] pc_4_MEMWB,
    output logic            halt_WB
);

    mem_state_t      state_q, state_d;
    logic            is_load, is_store, is_access, misaligned;
    logic            req_c, stall_c, retire, fault_d;
    logic [XLEN-1:0] ext_data;

    logic [XLEN-1:0] alu_q, alu_d, load_data_q, load_data_d, pc_4_q, pc_4_d;
    logic            reg_wr_en_q, reg_wr_en_d, halt_q, halt_d, fault_q;
    logic [1:0]      reg_wr_ctrl_q, reg_wr_ctrl_d;
    logic [4:0]      rd_q, rd_d;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata   (dmem_rdata),
        .addr_lo (ALU_out_EXMEM[1:0]),
        .funct3  (funct3_EXMEM),
        .result  (ext_data)
    );

    always_comb begin
        is_load    = reg_wr_en_EXMEM && (reg_wr_ctrl_EXMEM == WB_LOAD);
        is_store   = mem_wr_en_EXMEM;
        is_access  = is_load || is_store;
        misaligned = ((funct3_EXMEM[1:0] == 2'b01) && ALU_out_EXMEM[0]) ||
                     ((funct3_EXMEM[1:0] == 2'b10) && (ALU_out_EXMEM[1:0] != 2'b00));
    end

    // Store lane steering; loads always fetch the whole word.
    always_comb begin
        dmem_addr  = {ALU_out_EXMEM[XLEN-1:2], 2'b00};
        dmem_we    = is_store;
        dmem_be    = 4'b1111;
        dmem_wdata = rs2_data_EXMEM;
        if (is_store) begin
            case (funct3_EXMEM[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << ALU_out_EXMEM[1:0];
                    dmem_wdata = {4{rs2_data_EXMEM[7:0]}};
                end
                2'b01: begin
                    dmem_be    = 4'b0011 << {ALU_out_EXMEM[1], 1'b0};
                    dmem_wdata = {2{rs2_data_EXMEM[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        retire  = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!is_access) begin
                    retire = 1'b1;
                end else if (misaligned) begin
                    fault_d = 1'b1;
                end else begin
                    req_c = 1'b1;
                    if (dmem_ready && (is_store || dmem_rvalid)) begin
                        retire = 1'b1;
                    end else if (dmem_ready) begin
                        state_d = S_WAIT_RSP;
                        stall_c = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        stall_c = 1'b1;
                    end
                end
            end
            S_REQ: begin
                req_c = 1'b1;
                if (dmem_ready && is_store) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end else if (dmem_ready) begin
                    state_d = S_WAIT_RSP;
                    stall_c = 1'b1;
                end else begin
                    stall_c = 1'b1;
                end
            end
            S_WAIT_RSP: begin
                if (dmem_rvalid) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Non-retiring cycles load a bubble; a misaligned access keeps its halt marker.
    always_comb begin
        alu_d         = ALU_out_EXMEM;
        rd_d          = rd_EXMEM;
        pc_4_d        = pc_4_EXMEM;
        reg_wr_ctrl_d = reg_wr_ctrl_EXMEM;
        reg_wr_en_d   = retire && reg_wr_en_EXMEM;
        halt_d        = (retire || fault_d) && halt_MEM;
        load_data_d   = (retire && is_load) ? ext_data : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            alu_q         <= '0;
            load_data_q   <= '0;
            pc_4_q        <= '0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_ctrl_q <= '0;
            rd_q          <= '0;
            halt_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_q         <= alu_d;
            load_data_q   <= load_data_d;
            pc_4_q        <= pc_4_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_ctrl_q <= reg_wr_ctrl_d;
            rd_q          <= rd_d;
            halt_q        <= halt_d;
            fault_q       <= fault_d;
        end
    end

    assign dmem_req          = req_c && reset;
    assign mem_stall         = stall_c && reset;
    assign misaligned_fault  = fault_q;
    assign ALU_out_MEMWB     = alu_q;
    assign load_data_MEMWB   = load_data_q;
    assign reg_wr_en_MEMWB   = reg_wr_en_q;
    assign reg_wr_ctrl_MEMWB = reg_wr_ctrl_q;
    assign rd_MEMWB          = rd_q;
    assign pc_4_MEMWB        = pc_4_q;
    assign halt_WB           = halt_q;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed cases followed by randomized transactions
// checked against a transaction-level reference model.
module tb_memory_access;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALU_out_EXMEM, rs2_data_EXMEM, pc_4_EXMEM;
    logic [2:0]  funct3_EXMEM;
    logic        mem_wr_en_EXMEM, reg_wr_en_EXMEM, halt_MEM;
    logic [1:0]  reg_wr_ctrl_EXMEM;
    logic [4:0]  rd_EXMEM;
    logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, misaligned_fault;
    logic [31:0] ALU_out_MEMWB, load_data_MEMWB, pc_4_MEMWB;
    logic        reg_wr_en_MEMWB, halt_WB;
    logic [1:0]  reg_wr_ctrl_MEMWB;
    logic [4:0]  rd_MEMWB;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_access #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .ALU_out_EXMEM(ALU_out_EXMEM), .funct3_EXMEM(funct3_EXMEM),
        .mem_wr_en_EXMEM(mem_wr_en_EXMEM), .rs2_data_EXMEM(rs2_data_EXMEM),
        .reg_wr_en_EXMEM(reg_wr_en_EXMEM), .reg_wr_ctrl_EXMEM(reg_wr_ctrl_EXMEM),
        .rd_EXMEM(rd_EXMEM), .pc_4_EXMEM(pc_4_EXMEM), .halt_MEM(halt_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .misaligned_fault(misaligned_fault),
        .ALU_out_MEMWB(ALU_out_MEMWB), .load_data_MEMWB(load_data_MEMWB),
        .reg_wr_en_MEMWB(reg_wr_en_MEMWB), .reg_wr_ctrl_MEMWB(reg_wr_ctrl_MEMWB),
        .rd_MEMWB(rd_MEMWB), .pc_4_MEMWB(pc_4_MEMWB), .halt_WB(halt_WB)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: access size in bytes from funct3, alignment by modulo.
    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
        return (a % size_bytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * (a % 4));
        case (f3)
            F3_LB:   return (sh[7]  ? 32'hFFFF_FF00 : 32'h0) | (sh & 32'hFF);
            F3_LBU:  return sh & 32'hFF;
            F3_LH:   return (sh[15] ? 32'hFFFF_0000 : 32'h0) | (sh & 32'hFFFF);
            F3_LHU:  return sh & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = size_bytes(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (size_bytes(f3))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // kind: 0 = non-memory op, 1 = load, 2 = store. Called just after a falling edge.
    task automatic run_txn(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [31:0] rdata,
                           input int dr, input int dv, input logic [1:0] alu_ctrl,
                           input bit alu_wen, input bit halt);
        bit mis, access, wen;
        int done;
        logic [4:0]  rd;
        logic [31:0] pc4;
        rd  = 5'($urandom);
        pc4 = $urandom;
        wen = (kind == 1) ? 1'b1 : (kind == 2) ? 1'b0 : alu_wen;
        ALU_out_EXMEM     = addr;
        funct3_EXMEM      = f3;
        mem_wr_en_EXMEM   = (kind == 2);
        rs2_data_EXMEM    = rs2;
        reg_wr_en_EXMEM   = wen;
        reg_wr_ctrl_EXMEM = (kind == 1) ? WB_LOAD : (kind == 2) ? WB_ALU : alu_ctrl;
        rd_EXMEM          = rd;
        pc_4_EXMEM        = pc4;
        halt_MEM          = halt;
        mis    = (kind != 0) && model_mis(f3, addr);
        access = (kind != 0) && !mis;
        done   = !access ? 0 : (kind == 2) ? dr : dr + dv;
        for (int k = 0; k <= done; k++) begin
            dmem_ready  = access && (k == dr);
            dmem_rvalid = (kind == 0) ? 1'($urandom) : (access && kind == 1 && k == dr + dv);
            dmem_rdata  = dmem_rvalid ? rdata : $urandom;
            #1;
            chk("req", 32'(dmem_req), 32'(access && k <= dr));
            chk("stall", 32'(mem_stall), 32'(k < done));
            if (access && k <= dr) begin
                chk("addr", dmem_addr, addr & 32'hFFFF_FFFC);
                chk("we", 32'(dmem_we), 32'(kind == 2));
                chk("be", 32'(dmem_be), (kind == 2) ? 32'(model_be(f3, addr)) : 32'hF);
                if (kind == 2) chk("wdata", dmem_wdata, model_wdata(f3, rs2));
            end
            @(posedge clk);
            #1;
            if (k == done) begin
                chk("wb_wen", 32'(reg_wr_en_MEMWB), 32'(wen && !mis));
                chk("wb_halt", 32'(halt_WB), 32'(halt));
                chk("fault", 32'(misaligned_fault), 32'(mis));
                if (!mis) begin
                    chk("wb_alu", ALU_out_MEMWB, addr);
                    chk("wb_rd", 32'(rd_MEMWB), 32'(rd));
                    chk("wb_pc4", pc_4_MEMWB, pc4);
                    chk("wb_ctrl", 32'(reg_wr_ctrl_MEMWB), 32'(reg_wr_ctrl_EXMEM));
                    chk("wb_load", load_data_MEMWB, (kind == 1) ? model_load(f3, addr, rdata) : 32'h0);
                end
            end else begin
                chk("bubble_wen", 32'(reg_wr_en_MEMWB), 32'h0);
                chk("bubble_halt", 32'(halt_WB), 32'h0);
                chk("bubble_fault", 32'(misaligned_fault), 32'h0);
            end
            @(negedge clk);
        end
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];

    initial begin
        int kind, dr, dv;
        logic [2:0]  f3;
        logic [31:0] a;

        ld_f3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        st_f3 = '{F3_SB, F3_SH, F3_SW};
        reset = 1'b0;
        ALU_out_EXMEM = '0; funct3_EXMEM = '0; mem_wr_en_EXMEM = 1'b0;
        rs2_data_EXMEM = '0; reg_wr_en_EXMEM = 1'b0; reg_wr_ctrl_EXMEM = '0;
        rd_EXMEM = '0; pc_4_EXMEM = '0; halt_MEM = 1'b0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_stall", 32'(mem_stall), 32'h0);
        chk("rst_wen", 32'(reg_wr_en_MEMWB), 32'h0);
        chk("rst_fault", 32'(misaligned_fault), 32'h0);
        chk("rst_alu", ALU_out_MEMWB, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        run_txn(2, F3_SW, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, WB_ALU, 0, 0);
        run_txn(2, F3_SB, 32'h103, 32'h0000_00A5, 0, 0, 0, WB_ALU, 0, 0);
        run_txn(1, F3_LB,  32'h102, 0, 32'h1280_FF00, 0, 1, WB_ALU, 0, 0);
        run_txn(1, F3_LBU, 32'h102, 0, 32'h1280_FF00, 0, 1, WB_ALU, 0, 0);
        run_txn(1, F3_LH,  32'h102, 0, 32'h1280_FF00, 0, 1, WB_ALU, 0, 0);
        run_txn(1, F3_LW,  32'h200, 0, 32'h8765_4321, 3, 2, WB_ALU, 0, 1);
        run_txn(1, F3_LW,  32'h101, 0, 32'h0, 0, 0, WB_ALU, 0, 1);
        run_txn(2, F3_SH,  32'h302, 32'h1234_5678, 0, 2, 0, WB_ALU, 0, 0);
        run_txn(1, F3_LHU, 32'h106, 0, 32'h9ABC_0000, 0, 0, WB_ALU, 0, 0);

        // Reset while waiting for read data; the late response must be dropped.
        ALU_out_EXMEM = 32'h400; funct3_EXMEM = F3_LW; mem_wr_en_EXMEM = 1'b0;
        reg_wr_en_EXMEM = 1'b1; reg_wr_ctrl_EXMEM = WB_LOAD; halt_MEM = 1'b1;
        dmem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dmem_ready = 1'b0;
        chk("wait_stall", 32'(mem_stall), 32'h1);
        reset = 1'b0;
        #1;
        chk("rstw_req", 32'(dmem_req), 32'h0);
        chk("rstw_stall", 32'(mem_stall), 32'h0);
        chk("rstw_wen", 32'(reg_wr_en_MEMWB), 32'h0);
        chk("rstw_halt", 32'(halt_WB), 32'h0);
        chk("rstw_alu", ALU_out_MEMWB, 32'h0);
        chk("rstw_rd", 32'(rd_MEMWB), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        reg_wr_en_EXMEM = 1'b0;
        halt_MEM = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        #1;
        chk("late_stall", 32'(mem_stall), 32'h0);
        chk("late_req", 32'(dmem_req), 32'h0);
        @(posedge clk);
        #1;
        chk("late_wen", 32'(reg_wr_en_MEMWB), 32'h0);
        chk("late_load", load_data_MEMWB, 32'h0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        run_txn(1, F3_LW, 32'h500, 0, 32'h1357_9BDF, 0, 0, WB_ALU, 0, 0);

        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 2);
            f3 = (kind == 1) ? ld_f3[$urandom_range(0, 4)] : st_f3[$urandom_range(0, 2)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(size_bytes(f3) - 1);
            dr = $urandom_range(0, 3);
            dv = $urandom_range(0, 3);
            if (dr > 0 && dv == 0) dv = 1;
            run_txn(kind, f3, a, $urandom, $urandom, dr, dv,
                    ($urandom_range(0, 1) != 0) ? WB_PC4 : WB_ALU,
                    1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
